// File: rtl/arb2_mux_ctrl.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 output mux.
// Bounds consecutive beats per grant under contention; output channel is valid/ready.
module arb2_mux_ctrl #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a_data,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b_data,
    output logic             ack_b,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic             SRC_A    = 1'b1;
    localparam logic             SRC_B    = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             sel_nx;
    logic             last_served;
    logic             last_nx;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             beat;
    logic             enter_a;
    logic             enter_b;

    // State, select, fairness pointer and burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= SRC_B;
            last_served <= SRC_B;
            beat_cnt    <= '0;
        end else begin
            state       <= state_nx;
            sel         <= sel_nx;
            last_served <= last_nx;
            beat_cnt    <= cnt_nx;
        end
    end

    // Next-state decision and channel handshake
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        last_nx   = last_served;
        cnt_nx    = beat_cnt;
        enter_a   = 1'b0;
        enter_b   = 1'b0;

        out_valid = ((state == GNT_A) && req_a) || ((state == GNT_B) && req_b);
        ack_a     = (state == GNT_A) && req_a && out_ready;
        ack_b     = (state == GNT_B) && req_b && out_ready;
        beat      = out_valid && out_ready;
        busy      = (state != IDLE);
        out_data  = sel ? a_data : b_data;

        case (state)
            IDLE: begin
                // On a tie the side not served most recently wins
                if (req_a && (!req_b || (last_served == SRC_B))) begin
                    enter_a = 1'b1;
                end else if (req_b) begin
                    enter_b = 1'b1;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    if (req_b) enter_b = 1'b1;
                    else       state_nx = IDLE;
                end else if (beat) begin
                    if (beat_cnt == CNT_LAST) begin
                        if (req_b) enter_b = 1'b1;
                    end else begin
                        cnt_nx = beat_cnt + CNT_W'(1);
                    end
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    if (req_a) enter_a = 1'b1;
                    else       state_nx = IDLE;
                end else if (beat) begin
                    if (beat_cnt == CNT_LAST) begin
                        if (req_a) enter_a = 1'b1;
                    end else begin
                        cnt_nx = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Grant entry: select moves on the same edge as the state
        if (enter_a) begin
            state_nx = GNT_A;
            sel_nx   = SRC_A;
            last_nx  = SRC_A;
            cnt_nx   = '0;
        end else if (enter_b) begin
            state_nx = GNT_B;
            sel_nx   = SRC_B;
            last_nx  = SRC_B;
            cnt_nx   = '0;
        end
    end

endmodule
